// File: rtl/CorePack.sv
// Shared core definitions: memory operation encoding from the decoder.
package CorePack;

  typedef enum logic [2:0] {
    MEM_NO = 3'd0,
    MEM_B  = 3'd1,
    MEM_H  = 3'd2,
    MEM_W  = 3'd3,
    MEM_D  = 3'd4,
    MEM_UB = 3'd5,
    MEM_UH = 3'd6,
    MEM_UW = 3'd7
  } mem_op_enum;

endpackage

// File: rtl/mem_req_responder.sv
// Memory-side responder for the core load/store port. Executes one request
// at a time against a synchronous single-port 64-bit RAM, splitting
// doubleword-crossing accesses into two beats and returning extended load
// data through a valid/ready response channel.
module mem_req_responder #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  CorePack::mem_op_enum    req_op,
  input  logic [63:0]             req_addr,
  input  logic [63:0]             req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [63:0]             resp_rdata,
  output logic                    resp_err,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [7:0]              ram_wmask,
  output logic [63:0]             ram_wdata,
  input  logic [63:0]             ram_rdata
);

  import CorePack::*;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT0 = 2'd1;
  localparam logic [1:0] S_BEAT1 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  function automatic logic [3:0] op_size(input mem_op_enum op);
    case (op)
      MEM_B, MEM_UB: op_size = 4'd1;
      MEM_H, MEM_UH: op_size = 4'd2;
      MEM_W, MEM_UW: op_size = 4'd4;
      MEM_D:         op_size = 4'd8;
      default:       op_size = 4'd0;
    endcase
  endfunction

  logic [1:0]        state;
  logic              r_we;
  mem_op_enum        r_op;
  logic [2:0]        r_off;
  logic [ADDR_W-1:0] r_dw0;
  logic [63:0]       r_wdata;
  logic              r_cross;
  logic              r_err;
  logic [63:0]       beat0_q;

  // Incoming request decode, evaluated at the request handshake
  logic [2:0]        in_off;
  logic [ADDR_W-1:0] in_dw0;
  logic [3:0]        in_size;
  logic              in_cross;
  logic              in_err;

  assign in_off   = req_addr[2:0];
  assign in_dw0   = req_addr[ADDR_W+2:3];
  assign in_size  = op_size(req_op);
  assign in_cross = ({1'b0, in_off} + in_size) > 4'd8;
  assign in_err   = (req_addr[63:ADDR_W+3] != '0) || (in_cross && (in_dw0 == '1));

  // Store alignment: data and byte mask spread over two doublewords
  logic [3:0]   r_size;
  logic [63:0]  wdata_trunc;
  logic [7:0]   size_mask;
  logic [127:0] st_word;
  logic [15:0]  st_mask;

  assign r_size = op_size(r_op);

  // Truncate store data and build the unshifted byte mask for the access size
  always_comb begin
    wdata_trunc = '0;
    size_mask   = '0;
    case (r_size)
      4'd1: begin wdata_trunc = {56'd0, r_wdata[7:0]};  size_mask = 8'h01; end
      4'd2: begin wdata_trunc = {48'd0, r_wdata[15:0]}; size_mask = 8'h03; end
      4'd4: begin wdata_trunc = {32'd0, r_wdata[31:0]}; size_mask = 8'h0F; end
      4'd8: begin wdata_trunc = r_wdata;                size_mask = 8'hFF; end
      default: ;
    endcase
  end

  assign st_word = {64'd0, wdata_trunc} << {r_off, 3'b000};
  assign st_mask = {8'd0, size_mask} << r_off;

  // Load assembly: for a crossing load beat0 was captured in BEAT1 and the
  // live RAM output is beat1; otherwise the live RAM output is beat0.
  logic [63:0] lo_beat;
  logic [63:0] hi_beat;
  logic [63:0] ld_word;
  logic [63:0] ld_result;

  assign lo_beat = r_cross ? beat0_q   : ram_rdata;
  assign hi_beat = r_cross ? ram_rdata : '0;
  assign ld_word = 64'({hi_beat, lo_beat} >> {r_off, 3'b000});

  // Truncate and extend the shifted load word; stores and errors return 0
  always_comb begin
    ld_result = '0;
    case (r_op)
      MEM_B:  ld_result = {{56{ld_word[7]}},  ld_word[7:0]};
      MEM_H:  ld_result = {{48{ld_word[15]}}, ld_word[15:0]};
      MEM_W:  ld_result = {{32{ld_word[31]}}, ld_word[31:0]};
      MEM_D:  ld_result = ld_word;
      MEM_UB: ld_result = {56'd0, ld_word[7:0]};
      MEM_UH: ld_result = {48'd0, ld_word[15:0]};
      MEM_UW: ld_result = {32'd0, ld_word[31:0]};
      default: ;
    endcase
    if (r_err || r_we) ld_result = '0;
  end

  // RAM port drive; all write-side outputs stay 0 unless a beat is active
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wmask = '0;
    ram_wdata = '0;
    case (state)
      S_BEAT0: begin
        if (r_op != MEM_NO && !r_err) begin
          ram_en   = 1'b1;
          ram_we   = r_we;
          ram_addr = r_dw0;
          if (r_we) begin
            ram_wmask = st_mask[7:0];
            ram_wdata = st_word[63:0];
          end
        end
      end
      S_BEAT1: begin
        ram_en   = 1'b1;
        ram_we   = r_we;
        ram_addr = r_dw0 + 1'b1;
        if (r_we) begin
          ram_wmask = st_mask[15:8];
          ram_wdata = st_word[127:64];
        end
      end
      default: ;
    endcase
  end

  // Request capture, beat sequencing and response hold
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      r_we       <= 1'b0;
      r_op       <= MEM_NO;
      r_off      <= '0;
      r_dw0      <= '0;
      r_wdata    <= '0;
      r_cross    <= 1'b0;
      r_err      <= 1'b0;
      beat0_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_we      <= req_we;
            r_op      <= req_op;
            r_off     <= in_off;
            r_dw0     <= in_dw0;
            r_wdata   <= req_wdata;
            r_cross   <= in_cross;
            r_err     <= in_err;
            req_ready <= 1'b0;
            state     <= S_BEAT0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_BEAT0: state <= (r_cross && !r_err) ? S_BEAT1 : S_RESP;
        S_BEAT1: begin
          beat0_q <= ram_rdata;
          state   <= S_RESP;
        end
        S_RESP: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_rdata <= ld_result;
            resp_err   <= r_err;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_responder.sv
// Testbench for mem_req_responder: behavioural RAM, vector table with a
// response scoreboard, and hand sequences for stall and mid-access reset.
module tb_mem_req_responder;

  import CorePack::*;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  mem_op_enum        req_op;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wmask;
  logic [63:0]       ram_wdata;
  logic [63:0]       ram_rdata;
  logic              preload;

  always #5 clk = ~clk;

  mem_req_responder #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wmask  (ram_wmask),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Synchronous single-port RAM with byte-masked writes
  logic [63:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= '0;
      mem[2] <= 64'h1122334455667788;
    end else if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 8; b++)
          if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  typedef struct {
    logic              we;
    mem_op_enum        op;
    logic [63:0]       addr;
    logic [63:0]       wdata;
    logic [63:0]       exp_rdata;
    logic              exp_err;
    int unsigned       exp_lat;
    int unsigned       exp_beats;
    logic              chk_beats;
    logic [ADDR_W-1:0] a0, a1;
    logic [7:0]        m0, m1;
    logic [63:0]       w0, w1;
  } vec_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic void add(input logic we, input mem_op_enum op, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [63:0] rdata, input logic err,
                              input int unsigned lat, input int unsigned beats);
    vec_t v;
    v.we = we; v.op = op; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_beats = beats;
    v.chk_beats = 1'b0;
    v.a0 = '0; v.a1 = '0; v.m0 = '0; v.m1 = '0; v.w0 = '0; v.w1 = '0;
    vecs.push_back(v);
  endfunction

  function automatic void add_beats(input logic [ADDR_W-1:0] a0, input logic [7:0] m0,
                                    input logic [63:0] w0, input logic [ADDR_W-1:0] a1,
                                    input logic [7:0] m1, input logic [63:0] w1);
    vec_t v;
    v = vecs.pop_back();
    v.chk_beats = 1'b1;
    v.a0 = a0; v.m0 = m0; v.w0 = w0; v.a1 = a1; v.m1 = m1; v.w1 = w1;
    vecs.push_back(v);
  endfunction

  task automatic run_req(input int idx, input vec_t v);
    int unsigned       n, k, beats;
    logic [ADDR_W-1:0] ca [2];
    logic [7:0]        cm [2];
    logic [63:0]       cw [2];
    exp_t              e;
    for (int i = 0; i < 2; i++) begin ca[i] = '0; cm[i] = '0; cw[i] = '0; end
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check($sformatf("v%0d_accept", idx), {63'd0, req_ready}, 64'd1);
    if (!req_ready) begin req_valid = 1'b0; return; end
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_op = MEM_NO; req_addr = '0; req_wdata = '0;
    k = 1; beats = 0;
    while (!resp_valid && k < 20) begin
      if (ram_en) begin
        if (beats < 2) begin
          ca[beats] = ram_addr; cm[beats] = ram_wmask; cw[beats] = ram_wdata;
        end
        beats++;
      end
      @(negedge clk); k++;
    end
    check($sformatf("v%0d_latency", idx), 64'(k), 64'(v.exp_lat));
    check($sformatf("v%0d_ram_beats", idx), 64'(beats), 64'(v.exp_beats));
    if (v.chk_beats) begin
      check($sformatf("v%0d_b0_addr", idx), 64'(ca[0]), 64'(v.a0));
      check($sformatf("v%0d_b0_mask", idx), 64'(cm[0]), 64'(v.m0));
      check($sformatf("v%0d_b0_wdata", idx), cw[0], v.w0);
      if (v.exp_beats == 2) begin
        check($sformatf("v%0d_b1_addr", idx), 64'(ca[1]), 64'(v.a1));
        check($sformatf("v%0d_b1_mask", idx), 64'(cm[1]), 64'(v.m1));
        check($sformatf("v%0d_b1_wdata", idx), cw[1], v.w1);
      end
    end
    e = sb.pop_front();
    check($sformatf("v%0d_resp_valid", idx), {63'd0, resp_valid}, 64'd1);
    check($sformatf("v%0d_rdata", idx), resp_rdata, e.rdata);
    check($sformatf("v%0d_err", idx), {63'd0, resp_err}, {63'd0, e.err});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    exp_t e;
    vec_t v;

    add(0, MEM_D,  64'h10,   '0, 64'h1122334455667788, 0, 3, 1);
    add(1, MEM_B,  64'h17,   64'h80, '0, 0, 3, 1);
    add(0, MEM_B,  64'h17,   '0, 64'hFFFFFFFFFFFFFF80, 0, 3, 1);
    add(0, MEM_UB, 64'h17,   '0, 64'h0000000000000080, 0, 3, 1);
    add(0, MEM_H,  64'h16,   '0, 64'hFFFFFFFFFFFF8022, 0, 3, 1);
    add(0, MEM_UH, 64'h16,   '0, 64'h0000000000008022, 0, 3, 1);
    add(0, MEM_W,  64'h14,   '0, 64'hFFFFFFFF80223344, 0, 3, 1);
    add(0, MEM_UW, 64'h14,   '0, 64'h0000000080223344, 0, 3, 1);
    add(1, MEM_W,  64'h0E,   64'hDEADBEEFAABBCCDD, '0, 0, 4, 2);
    add_beats(1, 8'hC0, 64'hCCDD000000000000, 2, 8'h03, 64'h000000000000AABB);
    add(0, MEM_W,  64'h0E,   '0, 64'hFFFFFFFFAABBCCDD, 0, 4, 2);
    add(0, MEM_UW, 64'h0E,   '0, 64'h00000000AABBCCDD, 0, 4, 2);
    add(0, MEM_D,  64'h10,   '0, 64'h802233445566AABB, 0, 3, 1);
    add(1, MEM_D,  64'h1D,   64'h0102030405060708, '0, 0, 4, 2);
    add_beats(3, 8'hE0, 64'h0607080000000000, 4, 8'h1F, 64'h0000000102030405);
    add(0, MEM_D,  64'h1D,   '0, 64'h0102030405060708, 0, 4, 2);
    add(0, MEM_H,  64'h1F,   '0, 64'h0000000000000506, 0, 4, 2);
    add(0, MEM_W,  64'h1C,   '0, 64'h0000000006070800, 0, 3, 1);
    add(0, MEM_D,  64'h2000, '0, '0, 1, 3, 0);
    add(0, MEM_D,  64'h1FFC, '0, '0, 1, 3, 0);
    add(1, MEM_W,  64'h1FFE, 64'h12345678, '0, 1, 3, 0);
    add(1, MEM_D,  64'h4000000000000000, 64'hFFFFFFFFFFFFFFFF, '0, 1, 3, 0);
    add(1, MEM_B,  64'h1FFF, 64'h5A, '0, 0, 3, 1);
    add_beats(10'h3FF, 8'h80, 64'h5A00000000000000, 0, 8'h00, '0);
    add(0, MEM_UB, 64'h1FFF, '0, 64'h000000000000005A, 0, 3, 1);
    add(0, MEM_D,  64'h1FF8, '0, 64'h5A00000000000000, 0, 3, 1);
    add(0, MEM_W,  64'h1FFC, '0, 64'h000000005A000000, 0, 3, 1);
    add(0, MEM_NO, 64'h40,   '0, '0, 0, 3, 0);
    add(1, MEM_NO, 64'h48,   64'hFFFF, '0, 0, 3, 0);

    // Reset: two cycles low, everything quiet; ready the cycle after release
    preload = 1'b1; rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_op = MEM_NO;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_ram_ctl", {60'd0, ram_en, ram_we, 2'b00}, 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_wmask", 64'(ram_wmask), 64'd0);
    check("rst_ram_wdata", ram_wdata, 64'd0);
    preload = 1'b0; rstn = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_req(i, v);
    end

    // Response backpressure: output held, no new work while waiting
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_op = MEM_D; req_addr = 64'h10; req_wdata = '0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("stall_accept", {63'd0, req_ready}, 64'd1);
    sb.push_back('{rdata: 64'h802233445566AABB, err: 1'b0});
    @(negedge clk);
    req_valid = 1'b0; req_op = MEM_NO; req_addr = '0;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    check("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
    e = sb.pop_front();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", c), {63'd0, resp_valid}, 64'd1);
      check($sformatf("stall%0d_rdata", c), resp_rdata, e.rdata);
      check($sformatf("stall%0d_req_ready", c), {63'd0, req_ready}, 64'd0);
      check($sformatf("stall%0d_ram_en", c), {63'd0, ram_en}, 64'd0);
    end
    resp_ready = 1'b1;
    check("stall_err", {63'd0, resp_err}, {63'd0, e.err});
    @(negedge clk);
    check("stall_release_ready", {63'd0, req_ready}, 64'd1);
    check("stall_release_valid", {63'd0, resp_valid}, 64'd0);

    // Reset pulse during the second beat of a crossing store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_op = MEM_D; req_addr = 64'h2D;
    req_wdata = 64'hCAFEF00D12345678;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("rstmid_accept", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_op = MEM_NO; req_addr = '0; req_wdata = '0;
    check("rstmid_b0_en", {63'd0, ram_en}, 64'd1);
    check("rstmid_b0_addr", 64'(ram_addr), 64'd5);
    @(negedge clk);
    check("rstmid_b1_en", {63'd0, ram_en}, 64'd1);
    check("rstmid_b1_addr", 64'(ram_addr), 64'd6);
    rstn = 1'b0;
    @(negedge clk);
    check("rstmid_in_rst_valid", {63'd0, resp_valid}, 64'd0);
    check("rstmid_in_rst_ready", {63'd0, req_ready}, 64'd0);
    check("rstmid_in_rst_ram_en", {63'd0, ram_en}, 64'd0);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rstmid%0d_valid", c), {63'd0, resp_valid}, 64'd0);
      check($sformatf("rstmid%0d_ram_en", c), {63'd0, ram_en}, 64'd0);
      check($sformatf("rstmid%0d_ready", c), {63'd0, req_ready}, 64'd1);
    end

    v = vecs[0];
    v.addr = 64'h1D; v.exp_rdata = 64'h0102030405060708; v.exp_lat = 4; v.exp_beats = 2;
    run_req(99, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
